// File: rtl/slm_cmd_bridge.sv
// UART-to-SPI command bridge: parses w/q/r byte frames into SPI register accesses or a
// board reset pulse, and returns responses through a small FIFO drained into uart_tx.
module slm_cmd_bridge #(
  parameter int unsigned RESET_CYCLES   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned RESP_DEPTH     = 16,
  parameter logic [7:0]  READ_FLAG      = 8'h80
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  output logic       o_spi_start,
  output logic [7:0] o_spi_upper,
  output logic [7:0] o_spi_lower,
  input  logic       i_spi_busy,
  input  logic       i_spi_done,
  input  logic [7:0] i_spi_rx,
  output logic       o_reset_all,
  output logic       o_overflow,
  output logic       o_rx_dropped
);

  localparam int unsigned AW = $clog2(RESP_DEPTH);
  localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);

  localparam logic [7:0] CH_W   = 8'h77;
  localparam logic [7:0] CH_Q   = 8'h71;
  localparam logic [7:0] CH_R   = 8'h72;
  localparam logic [7:0] CH_K   = 8'h6B;
  localparam logic [7:0] CH_BAD = 8'h3F;
  localparam logic [7:0] CH_TMO = 8'h21;

  // state      | meaning
  // IDLE       | waiting for an opcode byte
  // GET_ADDR   | w/q received, waiting for address byte
  // GET_DATA   | w + address received, waiting for data byte
  // SPI_ISSUE  | frame complete, waiting for spi idle to start
  // SPI_WAIT   | transfer running, waiting for i_spi_done
  // RESET_HOLD | o_reset_all asserted, counting down
  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, SPI_ISSUE, SPI_WAIT, RESET_HOLD
  } state_t;

  state_t         state_q;
  logic           is_read_q;
  logic [GW-1:0]  gap_q;
  logic [RW-1:0]  rst_cnt_q;
  logic           spi_start_q;
  logic [7:0]     spi_upper_q;
  logic [7:0]     spi_lower_q;
  logic           reset_all_q;
  logic           rx_dropped_q;
  logic           push_q;
  logic [7:0]     push_byte_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      is_read_q    <= 1'b0;
      gap_q        <= '0;
      rst_cnt_q    <= '0;
      spi_start_q  <= 1'b0;
      spi_upper_q  <= 8'h00;
      spi_lower_q  <= 8'h00;
      reset_all_q  <= 1'b0;
      rx_dropped_q <= 1'b0;
      push_q       <= 1'b0;
      push_byte_q  <= 8'h00;
    end else begin
      spi_start_q <= 1'b0;
      push_q      <= 1'b0;
      if (i_rx_dv && (state_q inside {SPI_ISSUE, SPI_WAIT, RESET_HOLD}))
        rx_dropped_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (i_rx_dv) begin
            case (i_rx_byte)
              CH_W, CH_Q: begin
                is_read_q <= (i_rx_byte == CH_Q);
                gap_q     <= GW'(TIMEOUT_CYCLES - 1);
                state_q   <= GET_ADDR;
              end
              CH_R: begin
                reset_all_q <= 1'b1;
                rst_cnt_q   <= RW'(RESET_CYCLES - 1);
                state_q     <= RESET_HOLD;
              end
              default: begin
                push_q      <= 1'b1;
                push_byte_q <= CH_BAD;
              end
            endcase
          end
        end
        GET_ADDR: begin
          if (i_rx_dv) begin
            gap_q <= GW'(TIMEOUT_CYCLES - 1);
            if (is_read_q) begin
              spi_upper_q <= i_rx_byte | READ_FLAG;
              spi_lower_q <= 8'h00;
              state_q     <= SPI_ISSUE;
            end else begin
              spi_upper_q <= i_rx_byte & ~READ_FLAG;
              state_q     <= GET_DATA;
            end
          end else if (gap_q == '0) begin
            push_q      <= 1'b1;
            push_byte_q <= CH_TMO;
            state_q     <= IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        GET_DATA: begin
          if (i_rx_dv) begin
            spi_lower_q <= i_rx_byte;
            state_q     <= SPI_ISSUE;
          end else if (gap_q == '0) begin
            push_q      <= 1'b1;
            push_byte_q <= CH_TMO;
            state_q     <= IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        SPI_ISSUE: begin
          if (!i_spi_busy) begin
            spi_start_q <= 1'b1;
            state_q     <= SPI_WAIT;
          end
        end
        SPI_WAIT: begin
          if (i_spi_done) begin
            push_q      <= 1'b1;
            push_byte_q <= is_read_q ? i_spi_rx : CH_K;
            state_q     <= IDLE;
          end
        end
        RESET_HOLD: begin
          if (rst_cnt_q == '0) begin
            reset_all_q <= 1'b0;
            push_q      <= 1'b1;
            push_byte_q <= CH_K;
            state_q     <= IDLE;
          end else begin
            rst_cnt_q <= rst_cnt_q - RW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response FIFO: extra pointer MSB distinguishes full from empty.
  logic [7:0]  mem_q [RESP_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        overflow_q;
  logic        tx_pending_q;
  logic        tx_dv_q;
  logic [7:0]  tx_byte_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_push;
  logic        do_pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push    = push_q && !fifo_full;
  assign do_pop     = !fifo_empty && !i_tx_active && !tx_pending_q;

  always_ff @(posedge i_clock) begin
    if (do_push)
      mem_q[wr_ptr_q[AW-1:0]] <= push_byte_q;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      tx_pending_q <= 1'b0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
    end else begin
      if (do_push)
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (push_q && fifo_full)
        overflow_q <= 1'b1;
      tx_dv_q <= do_pop;
      // pending holds off the next strobe until uart_tx has visibly gone busy
      if (do_pop) begin
        tx_byte_q    <= mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q     <= rd_ptr_q + (AW+1)'(1);
        tx_pending_q <= 1'b1;
      end else if (i_tx_active) begin
        tx_pending_q <= 1'b0;
      end
    end
  end

  assign o_tx_dv      = tx_dv_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_spi_start  = spi_start_q;
  assign o_spi_upper  = spi_upper_q;
  assign o_spi_lower  = spi_lower_q;
  assign o_reset_all  = reset_all_q;
  assign o_overflow   = overflow_q;
  assign o_rx_dropped = rx_dropped_q;

endmodule

// File: tb/tb_slm_cmd_bridge.sv
// Scoreboard bench for slm_cmd_bridge: expected SPI starts and TX bytes are queued by the
// stimulus thread and consumed by a monitor; simple uart_tx and spi models drive handshakes.
module tb_slm_cmd_bridge;

  logic       clk;
  logic       i_reset;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       i_tx_active;
  logic       o_spi_start;
  logic [7:0] o_spi_upper;
  logic [7:0] o_spi_lower;
  logic       i_spi_busy;
  logic       i_spi_done;
  logic [7:0] i_spi_rx;
  logic       o_reset_all;
  logic       o_overflow;
  logic       o_rx_dropped;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_spi[$];

  bit         tx_hold = 1'b0;
  int         spi_lat = 3;
  logic [7:0] spi_rd_val = 8'h00;

  logic [28:0] outs;
  assign outs = {o_tx_dv, o_tx_byte, o_spi_start, o_spi_upper, o_spi_lower,
                 o_reset_all, o_overflow, o_rx_dropped};

  slm_cmd_bridge #(
    .RESET_CYCLES  (10),
    .TIMEOUT_CYCLES(100),
    .RESP_DEPTH    (2),
    .READ_FLAG     (8'h80)
  ) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_rx_dv     (i_rx_dv),
    .i_rx_byte   (i_rx_byte),
    .o_tx_dv     (o_tx_dv),
    .o_tx_byte   (o_tx_byte),
    .i_tx_active (i_tx_active),
    .o_spi_start (o_spi_start),
    .o_spi_upper (o_spi_upper),
    .o_spi_lower (o_spi_lower),
    .i_spi_busy  (i_spi_busy),
    .i_spi_done  (i_spi_done),
    .i_spi_rx    (i_spi_rx),
    .o_reset_all (o_reset_all),
    .o_overflow  (o_overflow),
    .o_rx_dropped(o_rx_dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // uart_tx model: busy goes high one cycle after the strobe, for three cycles
  initial begin
    i_tx_active = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_hold) begin
        i_tx_active = 1'b1;
      end else if (o_tx_dv) begin
        i_tx_active = 1'b0;
        @(negedge clk);
        i_tx_active = 1'b1;
        repeat (3) @(negedge clk);
        i_tx_active = 1'b0;
      end else begin
        i_tx_active = 1'b0;
      end
    end
  end

  // spi model: busy for spi_lat cycles after start, then a one-cycle done with read data
  initial begin
    i_spi_busy = 1'b0;
    i_spi_done = 1'b0;
    i_spi_rx   = 8'h00;
    forever begin
      @(negedge clk);
      i_spi_done = 1'b0;
      if (o_spi_start) begin
        i_spi_busy = 1'b1;
        repeat (spi_lat) @(negedge clk);
        i_spi_busy = 1'b0;
        i_spi_done = 1'b1;
        i_spi_rx   = spi_rd_val;
      end
    end
  end

  // monitor: tx_wait 0 = free, 1 = need busy high, 2 = need busy low
  initial begin
    int tx_wait;
    logic [7:0]  et;
    logic [15:0] es;
    tx_wait = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_wait == 1 && i_tx_active) tx_wait = 2;
      else if (tx_wait == 2 && !i_tx_active) tx_wait = 0;
      if (o_tx_dv) begin
        check("tx_handshake", 32'(tx_wait), 32'h0);
        tx_wait = 1;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: actual byte=0x%02h required=none", o_tx_byte);
        end else begin
          et = exp_tx.pop_front();
          check("tx_byte", 32'(o_tx_byte), 32'(et));
        end
      end
      if (o_spi_start) begin
        if (exp_spi.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spi_unexpected: actual upper/lower=0x%02h/0x%02h required=none",
                   o_spi_upper, o_spi_lower);
        end else begin
          es = exp_spi.pop_front();
          check("spi_upper_lower", 32'({o_spi_upper, o_spi_lower}), 32'(es));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    @(negedge clk);
    i_rx_dv   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_spi.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_tx.size() + exp_spi.size()), 32'h0);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int cnt;
    i_reset   = 1'b1;
    i_rx_dv   = 1'b0;
    i_rx_byte = 8'h00;
    repeat (5) @(negedge clk);
    check("outs_in_reset", 32'(outs), 32'h0);
    i_reset = 1'b0;
    @(negedge clk);
    check("outs_after_reset", 32'(outs), 32'h0);

    // writes, including an address with the read flag set that must be masked off
    exp_spi.push_back(16'h0932);
    exp_tx.push_back(8'h6B);
    send_byte(8'h77); send_byte(8'h09); send_byte(8'h32);
    drain("write1_drain");
    exp_spi.push_back(16'h253C);
    exp_tx.push_back(8'h6B);
    send_byte(8'h77); send_byte(8'hA5); send_byte(8'h3C);
    drain("write2_drain");

    // reads
    spi_rd_val = 8'h32;
    exp_spi.push_back(16'h8900);
    exp_tx.push_back(8'h32);
    send_byte(8'h71); send_byte(8'h09);
    drain("read1_drain");
    spi_rd_val = 8'hC7;
    exp_spi.push_back(16'h8500);
    exp_tx.push_back(8'hC7);
    send_byte(8'h71); send_byte(8'h85);
    drain("read2_drain");
    check("rx_dropped_clear", 32'(o_rx_dropped), 32'h0);
    check("overflow_clear", 32'(o_overflow), 32'h0);

    // reset pulse; a byte sent mid-pulse must be dropped, not answered
    exp_tx.push_back(8'h6B);
    @(negedge clk);
    i_rx_dv   = 1'b1;
    i_rx_byte = 8'h72;
    @(negedge clk);
    i_rx_dv   = 1'b0;
    check("reset_all_rise", 32'(o_reset_all), 32'h1);
    cnt = 0;
    while (o_reset_all && cnt < 50) begin
      cnt++;
      i_rx_dv   = (cnt == 3);
      i_rx_byte = 8'h5A;
      @(negedge clk);
    end
    i_rx_dv = 1'b0;
    check("reset_all_width", 32'(cnt), 32'd10);
    drain("reset_drain");
    check("rx_dropped_set", 32'(o_rx_dropped), 32'h1);

    // gaps just under the timeout must not abort the frame
    exp_spi.push_back(16'h10EE);
    exp_tx.push_back(8'h6B);
    send_byte(8'h77);
    repeat (95) @(negedge clk);
    send_byte(8'h10);
    repeat (95) @(negedge clk);
    send_byte(8'hEE);
    drain("slow_write_drain");

    // timeout then bad opcode
    exp_tx.push_back(8'h21);
    send_byte(8'h77); send_byte(8'h09);
    repeat (150) @(negedge clk);
    drain("timeout_drain");
    exp_tx.push_back(8'h3F);
    send_byte(8'h5A);
    drain("badop_drain");

    // overflow with a two-entry FIFO
    tx_hold = 1'b1;
    repeat (2) @(negedge clk);
    exp_tx.push_back(8'h3F);
    exp_tx.push_back(8'h3F);
    send_byte(8'h00); send_byte(8'h5A);
    repeat (4) @(negedge clk);
    check("overflow_at_full", 32'(o_overflow), 32'h0);
    send_byte(8'hFF); send_byte(8'h41);
    repeat (4) @(negedge clk);
    check("overflow_set", 32'(o_overflow), 32'h1);
    tx_hold = 1'b0;
    drain("overflow_drain");

    // reset in SPI_WAIT; the late done must produce nothing
    spi_lat = 20;
    exp_spi.push_back(16'h0932);
    send_byte(8'h77); send_byte(8'h09); send_byte(8'h32);
    repeat (8) @(negedge clk);
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("outs_mid_reset", 32'(outs), 32'h0);
    i_reset = 1'b0;
    repeat (30) @(negedge clk);
    check("outs_after_late_done", 32'(outs), 32'h0);
    spi_lat = 3;
    exp_spi.push_back(16'h2143);
    exp_tx.push_back(8'h6B);
    send_byte(8'h77); send_byte(8'h21); send_byte(8'h43);
    drain("post_reset_write_drain");

    repeat (20) @(negedge clk);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'h0);
    check("spi_queue_empty", 32'(exp_spi.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slm_cmd_bridge.md
# slm_cmd_bridge

Parametrised UART-to-SPI command bridge for the HoloBlade board. It replaces the single-byte command decode in the top level. It takes bytes from `uart_rx`, parses multi-byte frames into Bluejay SPI register writes and reads, and issues the board-wide reset pulse. Read data, acknowledgements and error codes go into an internal response FIFO, which the block drains into `uart_tx` with a proper busy handshake.

## Interface
- `RESET_CYCLES`, default 10: cycles `o_reset_all` is held high for an `r` command (≥1).
- `TIMEOUT_CYCLES`, default 5_000_000: maximum gap between bytes of one frame (100 ms at 50 MHz).
- `RESP_DEPTH`, default 16: response FIFO depth in bytes; must be a power of 2, ≥2.
- `READ_FLAG`, default 8'h80: OR-mask applied to the address byte for SPI reads.
- `i_clock`  in  1  system clock (`sys_clk`, 50 MHz).
- `i_reset`  in  1  reset; synchronous, active-high. Must not be driven from `o_reset_all`.
- `i_rx_dv`  in  1  one-cycle strobe from `uart_rx`.
- `i_rx_byte`  in  8  received byte, valid with `i_rx_dv`.
- `o_tx_dv`  out  1  one-cycle start strobe to `uart_tx`.
- `o_tx_byte`  out  8  byte to transmit, valid with `o_tx_dv`.
- `i_tx_active`  in  1  `uart_tx` busy flag.
- `o_spi_start`  out  1  one-cycle transfer start to `spi`.
- `o_spi_upper`  out  8  SPI upper byte (address).
- `o_spi_lower`  out  8  SPI lower byte (data).
- `i_spi_busy`  in  1  `spi` busy.
- `i_spi_done`  in  1  `spi` transaction-complete strobe.
- `i_spi_rx`  in  8  `spi` received lower byte, valid with `i_spi_done`.
- `o_reset_all`  out  1  board reset pulse.
- `o_overflow`  out  1  sticky: a response was dropped because the FIFO was full.
- `o_rx_dropped`  out  1  sticky: an RX byte arrived while the FSM could not accept it.

## Operation
- **Frames:** 3 types plus error handling.
  - `w`(0x77) A D: SPI write with upper=A&~`READ_FLAG`, lower=D; then push `k`(0x6B).
  - `q`(0x71) A: SPI read with upper=A|`READ_FLAG`, lower=0x00; then push `i_spi_rx`.
  - `r`(0x72): reset pulse; push `k` when the pulse ends.
  - Any other first byte: push `?`(0x3F) and stay in IDLE.
- **FSM states:** IDLE, GET_ADDR, GET_DATA, SPI_ISSUE, SPI_WAIT, RESET_HOLD.
  - IDLE→GET_ADDR on `w`/`q`; IDLE→RESET_HOLD on `r`.
  - GET_ADDR→GET_DATA (`w`) or →SPI_ISSUE (`q`).
  - GET_DATA→SPI_ISSUE.
  - SPI_ISSUE→SPI_WAIT on start.
  - SPI_WAIT→IDLE on `i_spi_done`.
  - RESET_HOLD→IDLE when the count expires.
- **Timeout:** a gap counter resets on each accepted byte in GET_ADDR/GET_DATA. When it reaches `TIMEOUT_CYCLES`, abort to IDLE and push `!`(0x21).
- **Dropped RX:** `i_rx_dv` in SPI_ISSUE, SPI_WAIT or RESET_HOLD is ignored and sets `o_rx_dropped`.
- **Response FIFO:**
  - Pointers are log2(`RESP_DEPTH`)+1 bits wide; full/empty come from MSB comparison.
  - A push while full drops the byte and sets `o_overflow`.
  - A push and pop in the same cycle are both honoured.
- **TX drain:**
  - Issue when FIFO non-empty, `i_tx_active`=0 and `tx_pending`=0.
  - On issue, pop the head onto `o_tx_byte`, assert `o_tx_dv` for 1 cycle, and set `tx_pending`.
  - `tx_pending` clears on the first cycle `i_tx_active`=1.
- **Reset:** applies to everything, including mid-frame and mid-SPI. The FSM returns to IDLE, the FIFO empties and both stickies clear. An outstanding `i_spi_done` arriving after reset is ignored.

## Timing
- **Reset values:** all outputs are 0 while `i_reset` is high and on the cycle after it deasserts. `o_spi_upper`/`o_spi_lower`/`o_tx_byte` read 0x00.
- **SPI start:** `o_spi_start` is registered. It pulses on the first SPI_ISSUE cycle with `i_spi_busy`=0, at the earliest 1 cycle after the last frame byte's `i_rx_dv`. Upper/lower bytes are stable from that cycle until SPI_WAIT exits.
- **Read/write response:** the push happens on the cycle after `i_spi_done`. The earliest `o_tx_dv` is 1 cycle after that push.
- **Reset pulse:** `o_reset_all` rises 1 cycle after the `r` byte and stays high exactly `RESET_CYCLES` cycles. `k` is pushed on the cycle it falls.
- **Back-to-back TX:** at most one `o_tx_dv` per `uart_tx` byte. No second strobe may occur before `i_tx_active` has been seen high and then low.

## Test plan
- **Write:** rx 0x77,0x09,0x32 → one `o_spi_start` with upper=0x09, lower=0x32; after done, TX emits 0x6B.
- **Read:** rx 0x71,0x09 with SPI model returning 0x32 → upper=0x89, lower=0x00; TX emits 0x32.
- **Reset:** rx 0x72 → `o_reset_all` high exactly 10 cycles; TX emits 0x6B.
- **Timeout and bad opcode:** rx 0x77,0x09 then silence with `TIMEOUT_CYCLES`=100 → no SPI start, TX emits 0x21. Then rx 0x5A → TX emits 0x3F.
- **Overflow:** `RESP_DEPTH`=2, hold `i_tx_active`=1, send 4 bad bytes → `o_overflow`=1. Then release `i_tx_active`=0 → exactly 2×0x3F transmitted.
- **Mid-operation reset:** assert `i_reset` in SPI_WAIT, then pulse `i_spi_done` → no TX output, all outputs 0, next `w` frame works normally.
